// File: rtl/invsqrt.sv
// Sequential IEEE-754 single-precision reciprocal square root: magic-constant seed plus NR_ITERS Newton-Raphson steps.
// Define INVSQRT_RNE_EN for round-to-nearest-even arithmetic; the default build truncates.
module invsqrt #(
  parameter int          NR_ITERS = 2,
  parameter logic [31:0] MAGIC    = 32'h5F3759DF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] float_in,
  output logic [31:0] float_out,
  output logic        ready
);

  localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, SQ = 3'd2, MH = 3'd3,
                         SUB  = 3'd4, UPD  = 3'd5, DONE = 3'd6;

`ifdef INVSQRT_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  logic [2:0]  state_r;
  logic [2:0]  cnt_r;
  logic [31:0] x_r, xh_r, y_r, t_r, s_r, float_out_r;
  logic        ready_r;
  logic [31:0] mul_a_s, mul_b_s, mul_res_s, sub_res_s, special_val_s, xh_s;
  logic        special_s;
  logic [2:0]  cnt_next_s;

  function automatic logic [24:0] round_m(input logic [23:0] m, input logic g, input logic s);
    logic inc;
    inc = RNE & g & (s | m[0]);
    return {1'b0, m} + {24'd0, inc};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]        p;
    logic signed [9:0]  e;
    logic [23:0]        m;
    logic               g, s;
    logic [24:0]        r;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
      return 32'h0000_0000;
    end else begin
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = $signed({2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127);
      if (p[47]) begin
        m = p[47:24]; g = p[23]; s = |p[22:0]; e = e + 10'sd1;
      end else begin
        m = p[46:23]; g = p[22]; s = |p[21:0];
      end
      r = round_m(m, g, s);
      if (r[24]) begin
        m = r[24:1]; e = e + 10'sd1;
      end else begin
        m = r[23:0];
      end
      if (e <= 10'sd0)        return 32'h0000_0000;
      else if (e >= 10'sd255) return {a[31] ^ b[31], 31'h7F80_0000};
      else                    return {a[31] ^ b[31], e[7:0], m[22:0]};
    end
  endfunction

  // 1.5 - t; t never exceeds 1.5 in the refinement loop, anything larger clamps to +0
  function automatic logic [31:0] fp_sub15(input logic [31:0] t);
    logic [63:0] a, bf, b, diff, n;
    logic [7:0]  d, e;
    logic [24:0] r;
    int          msb;
    a  = {24'hC0_0000, 40'd0};
    bf = {1'b1, t[22:0], 40'd0};
    d  = 8'd127 - t[30:23];
    if (t[31] || t[30:23] > 8'd127) begin
      return 32'h0000_0000;
    end else if (t[30:23] == 8'd0) begin
      return 32'h3FC0_0000;
    end else begin
      if (d >= 8'd64) b = 64'd1;
      else            b = (bf >> d) | {63'd0, |(bf & ((64'd1 << d) - 64'd1))};
      if (b >= a) begin
        return 32'h0000_0000;
      end else begin
        diff = a - b;
        msb  = 0;
        for (int i = 0; i < 64; i++) msb = diff[i] ? i : msb;
        n = diff << (63 - msb);
        r = round_m(n[63:40], n[39], |n[38:0]);
        e = 8'd64 + 8'(msb);
        if (r[24]) return {1'b0, e + 8'd1, r[23:1]};
        else       return {1'b0, e, r[22:0]};
      end
    end
  endfunction

  // shared multiplier operand steering
  always_comb begin
    mul_a_s = 32'h0000_0000;
    mul_b_s = 32'h0000_0000;
    case (state_r)
      SQ:      begin mul_a_s = y_r;  mul_b_s = y_r; end
      MH:      begin mul_a_s = xh_r; mul_b_s = t_r; end
      UPD:     begin mul_a_s = y_r;  mul_b_s = s_r; end
      default: begin mul_a_s = 32'h0000_0000; mul_b_s = 32'h0000_0000; end
    endcase
  end

  assign mul_res_s  = fp_mul(mul_a_s, mul_b_s);
  assign sub_res_s  = fp_sub15(t_r);
  assign cnt_next_s = cnt_r + 3'd1;
  assign xh_s       = (x_r[30:23] == 8'd1) ? 32'h0000_0000 : {x_r[31], x_r[30:23] - 8'd1, x_r[22:0]};

  // operand classification; denormals count as signed zero
  always_comb begin
    special_s     = 1'b1;
    special_val_s = 32'h7FC0_0000;
    if (x_r[30:23] == 8'd0) begin
      special_val_s = x_r[31] ? 32'hFF80_0000 : 32'h7F80_0000;
    end else if (x_r[30:23] == 8'hFF && x_r[22:0] == 23'd0 && !x_r[31]) begin
      special_val_s = 32'h0000_0000;
    end else if (x_r[30:23] == 8'hFF || x_r[31]) begin
      special_val_s = 32'h7FC0_0000;
    end else begin
      special_s     = 1'b0;
      special_val_s = 32'h0000_0000;
    end
  end

  // control FSM and datapath registers; outputs update one edge after DONE is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE; cnt_r <= 3'd0; ready_r <= 1'b0; float_out_r <= 32'h0000_0000;
      x_r <= 32'h0000_0000; xh_r <= 32'h0000_0000; y_r <= 32'h0000_0000;
      t_r <= 32'h0000_0000; s_r <= 32'h0000_0000;
    end else begin
      ready_r <= (state_r == DONE);
      if (state_r == DONE && !ready_r) float_out_r <= y_r;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            x_r     <= float_in;
            state_r <= INIT;
          end
        end
        INIT: begin
          if (special_s) begin
            y_r     <= special_val_s;
            state_r <= DONE;
          end else begin
            y_r     <= MAGIC - {1'b0, x_r[31:1]};
            xh_r    <= xh_s;
            cnt_r   <= 3'd0;
            state_r <= SQ;
          end
        end
        SQ:  begin t_r <= mul_res_s; state_r <= MH;  end
        MH:  begin t_r <= mul_res_s; state_r <= SUB; end
        SUB: begin s_r <= sub_res_s; state_r <= UPD; end
        UPD: begin
          y_r     <= mul_res_s;
          cnt_r   <= cnt_next_s;
          state_r <= (cnt_next_s < 3'(NR_ITERS)) ? SQ : DONE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign float_out = float_out_r;
  assign ready     = ready_r;

endmodule

// File: tb/tb_invsqrt.sv
// Directed bench for invsqrt: scoreboard of expected results, real-valued tolerance model for normal operands.
module tb_invsqrt;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] float_in = 32'h0000_0000;
  logic [31:0] float_out;
  logic        ready;

  invsqrt dut (.clk(clk), .rst(rst), .start(start), .float_in(float_in),
               .float_out(float_out), .ready(ready));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] x; logic exact; logic [31:0] val; } exp_t;
  exp_t sb_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  localparam real TOL = 2.0e-5;

  function automatic real sp2real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: got %b expected %b", tag, obs, expv);
  endtask

  task automatic checki(input string tag, input int obs, input int expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  task automatic check_tol(input string tag, input logic [31:0] obs, input logic [31:0] x);
    real e, r, rel;
    logic ok;
    e   = 1.0 / $sqrt(sp2real(x));
    r   = sp2real(obs);
    rel = (r - e) / e;
    if (rel < 0.0) rel = -rel;
    ok  = (rel <= TOL) && !obs[31] && (obs[30:23] != 8'hFF);
    total_cnt++;
    assert (ok === 1'b1) pass_cnt++;
    else $error("FAIL %s: got %h (%g) expected about %g (rel err %g)", tag, obs, r, e, rel);
  endtask

  // drive one operand, hold start across the acceptance edge and the one after, then score
  task automatic run_op(input logic [31:0] x, input logic [31:0] exp_val, input logic exact,
                        input int lat, input int glitch_at, input string tag);
    logic        was_ready, stable;
    logic [31:0] prev;
    int          n;
    exp_t        e, got;
    was_ready = ready;
    prev      = float_out;
    stable    = 1'b1;
    float_in  = x;
    start     = 1'b1;
    e.x = x; e.exact = exact; e.val = exp_val;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (was_ready) check1({tag, "_ready_held"}, ready, 1'b1);
    n = 0;
    do begin
      if (float_out !== prev) stable = 1'b0;
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        if (was_ready) check1({tag, "_ready_fall"}, ready, 1'b0);
      end
      if (glitch_at > 0 && n == glitch_at) begin
        start    = 1'b1;
        float_in = 32'h4000_0000;
      end
      if (glitch_at > 0 && n == glitch_at + 1) start = 1'b0;
    end while (!ready && n < 40);
    checki({tag, "_latency"}, n, lat);
    check1({tag, "_out_stable"}, stable, 1'b1);
    if (sb_q.size() == 0) begin
      checki({tag, "_sb_empty"}, 0, 1);
    end else begin
      got = sb_q.pop_front();
      if (got.exact) check32({tag, "_value"}, float_out, got.val);
      else           check_tol({tag, "_value"}, float_out, got.x);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] xr;
    repeat (10) @(posedge clk);
    #1;
    check1("reset_ready", ready, 1'b0);
    check32("reset_out", float_out, 32'h0000_0000);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'h4080_0000, 32'h3F00_0000, 1'b0, 10, 0, "four");
    run_op(32'h3E80_0000, 32'h4000_0000, 1'b0, 10, 0, "quarter");
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 10, 0, "one");

    run_op(32'h0000_0000, 32'h7F80_0000, 1'b1, 2, 0, "pos_zero");
    run_op(32'hBF80_0000, 32'h7FC0_0000, 1'b1, 2, 0, "neg_one");
    run_op(32'h7F80_0000, 32'h0000_0000, 1'b1, 2, 0, "pos_inf");
    run_op(32'h8000_0000, 32'hFF80_0000, 1'b1, 2, 0, "neg_zero");
    run_op(32'h7FC0_0001, 32'h7FC0_0000, 1'b1, 2, 0, "nan");
    run_op(32'hFF80_0000, 32'h7FC0_0000, 1'b1, 2, 0, "neg_inf");
    run_op(32'h0040_0000, 32'h7F80_0000, 1'b1, 2, 0, "denorm");

    for (int i = 0; i < 10; i++) begin
      xr = {1'b0, 8'($urandom_range(100, 154)), 23'($urandom)};
      run_op(xr, 32'h0000_0000, 1'b0, 10, 0, "b2b");
    end

    run_op(32'h4180_0000, 32'h3E80_0000, 1'b0, 10, 4, "glitch");

    float_in = 32'h4110_0000;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check1("abort_ready", ready, 1'b0);
    check32("abort_out", float_out, 32'h0000_0000);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check1("abort_no_result", ready, 1'b0);
    run_op(32'h4080_0000, 32'h3F00_0000, 1'b0, 10, 0, "after_abort");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
